// File: rtl/ghost_pkg.sv
// Shared types and constants for the ghost collision collector.
// Optional feature macro used by the collector: GHOST_HIT_PIXEL_COUNT_EN.
package ghost_pkg;

    localparam int unsigned NUM_EDGE_CODES = 5;
    localparam int unsigned EDGE_CODE_W    = 3;
    localparam int unsigned PIX_CNT_W      = 8;

    typedef enum logic [EDGE_CODE_W-1:0] {
        EDGE_BOTTOM = 3'd0,
        EDGE_LEFT   = 3'd1,
        EDGE_RIGHT  = 3'd2,
        EDGE_TOP    = 3'd3,
        EDGE_CORNER = 3'd4
    } hit_edge_t;

    typedef enum logic [1:0] {
        ST_WAIT_SOF = 2'd0,
        ST_COLLECT  = 2'd1,
        ST_PUBLISH  = 2'd2
    } coll_state_t;

    // Saturating increment for the wall-hit pixel counter.
    function automatic logic [PIX_CNT_W-1:0] sat_inc(input logic [PIX_CNT_W-1:0] v);
        return (v == '1) ? v : v + PIX_CNT_W'(1);
    endfunction

endpackage

// File: rtl/hit_edge_decoder.sv
// Converts a ghost hit-edge code into a one-hot edge vector; invalid codes
// or a deasserted enable give an all-zero vector.
import ghost_pkg::*;

module hit_edge_decoder #(
    parameter int unsigned EDGE_CODES = NUM_EDGE_CODES
) (
    input  logic                   en_i,
    input  logic [EDGE_CODE_W-1:0] code_i,
    output logic [EDGE_CODES-1:0]  onehot_o
);

    always_comb begin
        onehot_o = '0;
        for (int unsigned i = 0; i < EDGE_CODES; i++) begin
            onehot_o[i] = en_i && (code_i == EDGE_CODE_W'(i));
        end
    end

endmodule

// File: rtl/ghost_collision_collector.sv
// Turns per-pixel ghost/wall/pacman overlaps into frame-level collision events.
// Define GHOST_HIT_PIXEL_COUNT_EN to add the wallHitPixels saturating count output.
import ghost_pkg::*;

module ghost_collision_collector #(
    parameter int unsigned EDGE_CODES = NUM_EDGE_CODES
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   startOfFrame,
    input  logic                   ghostDrawingRequest,
    input  logic [EDGE_CODE_W-1:0] HitEdgeCode,
    input  logic                   wallDrawingRequest,
    input  logic                   pacmanDrawingRequest,
    output logic                   wallHitValid,
    output logic [EDGE_CODES-1:0]  wallHitEdges,
`ifdef GHOST_HIT_PIXEL_COUNT_EN
    output logic [PIX_CNT_W-1:0]   wallHitPixels,
`endif
    output logic                   pacmanCatch
);

    coll_state_t           state_q, state_d;
    logic [EDGE_CODES-1:0] edge_acc_q, edge_acc_d;
    logic                  caught_q, caught_d;
    logic                  valid_q, valid_d;
    logic [EDGE_CODES-1:0] edges_q, edges_d;
    logic                  catch_q, catch_d;

    logic                  collecting_c;
    logic                  pac_hit_c;
    logic [EDGE_CODES-1:0] edge_vec_c;

    assign collecting_c = (state_q != ST_WAIT_SOF);
    assign pac_hit_c    = collecting_c && ghostDrawingRequest && pacmanDrawingRequest;

    hit_edge_decoder #(
        .EDGE_CODES (EDGE_CODES)
    ) u_dec (
        .en_i     (collecting_c && ghostDrawingRequest && wallDrawingRequest),
        .code_i   (HitEdgeCode),
        .onehot_o (edge_vec_c)
    );

    // A startOfFrame cycle closes the old frame; its own pixel opens the new one.
    always_comb begin
        state_d    = state_q;
        edge_acc_d = edge_acc_q;
        caught_d   = caught_q;
        valid_d    = 1'b0;
        edges_d    = edges_q;
        catch_d    = 1'b0;
        case (state_q)
            ST_WAIT_SOF: begin
                if (startOfFrame) begin
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT, ST_PUBLISH: begin
                if (startOfFrame) begin
                    state_d    = ST_PUBLISH;
                    edges_d    = edge_acc_q;
                    valid_d    = |edge_acc_q;
                    edge_acc_d = edge_vec_c;
                    caught_d   = 1'b0;
                end else begin
                    state_d    = ST_COLLECT;
                    edge_acc_d = edge_acc_q | edge_vec_c;
                end
                if (pac_hit_c && (startOfFrame || !caught_q)) begin
                    catch_d  = 1'b1;
                    caught_d = 1'b1;
                end
            end
            default: state_d = ST_WAIT_SOF;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= ST_WAIT_SOF;
            edge_acc_q <= '0;
            caught_q   <= 1'b0;
            valid_q    <= 1'b0;
            edges_q    <= '0;
            catch_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_acc_q <= edge_acc_d;
            caught_q   <= caught_d;
            valid_q    <= valid_d;
            edges_q    <= edges_d;
            catch_q    <= catch_d;
        end
    end

    assign wallHitValid = valid_q;
    assign wallHitEdges = edges_q;
    assign pacmanCatch  = catch_q;

`ifdef GHOST_HIT_PIXEL_COUNT_EN
    logic [PIX_CNT_W-1:0] cnt_q, cnt_d;
    logic [PIX_CNT_W-1:0] pix_q, pix_d;

    // Only valid-code wall hits count, so the decoder output gates the counter.
    always_comb begin
        cnt_d = cnt_q;
        pix_d = pix_q;
        if (collecting_c) begin
            if (startOfFrame) begin
                pix_d = cnt_q;
                cnt_d = (|edge_vec_c) ? PIX_CNT_W'(1) : '0;
            end else if (|edge_vec_c) begin
                cnt_d = sat_inc(cnt_q);
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_q <= '0;
            pix_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            pix_q <= pix_d;
        end
    end

    assign wallHitPixels = pix_q;
`endif

endmodule

// File: tb/tb_ghost_collision_collector.sv
// Self-checking bench for ghost_collision_collector: directed scenarios plus
// randomized frames against a frame-level reference model.
module tb_ghost_collision_collector;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame;
    logic       ghostDrawingRequest;
    logic [2:0] HitEdgeCode;
    logic       wallDrawingRequest;
    logic       pacmanDrawingRequest;
    logic       wallHitValid;
    logic [4:0] wallHitEdges;
    logic       pacmanCatch;
`ifdef GHOST_HIT_PIXEL_COUNT_EN
    logic [7:0] wallHitPixels;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: frame-level view of the collector.
    bit         m_active;
    logic [4:0] m_mask;
    int         m_cnt;
    bit         m_caught;
    logic       exp_valid;
    logic [4:0] exp_edges;
    logic       exp_catch;
    logic [7:0] exp_pix;

    always #5 clk = ~clk;

    ghost_collision_collector dut (
        .clk                  (clk),
        .resetN               (resetN),
        .startOfFrame         (startOfFrame),
        .ghostDrawingRequest  (ghostDrawingRequest),
        .HitEdgeCode          (HitEdgeCode),
        .wallDrawingRequest   (wallDrawingRequest),
        .pacmanDrawingRequest (pacmanDrawingRequest),
        .wallHitValid         (wallHitValid),
        .wallHitEdges         (wallHitEdges),
`ifdef GHOST_HIT_PIXEL_COUNT_EN
        .wallHitPixels        (wallHitPixels),
`endif
        .pacmanCatch          (pacmanCatch)
    );

    task automatic model_reset();
        m_active  = 0;
        m_mask    = '0;
        m_cnt     = 0;
        m_caught  = 0;
        exp_valid = 1'b0;
        exp_edges = '0;
        exp_catch = 1'b0;
        exp_pix   = '0;
    endtask

    // Drive one pixel cycle, advance the model, then settle just after the edge.
    task automatic step(input logic sof, input logic g, input logic [2:0] code,
                        input logic w, input logic p);
        bit hw;
        bit hp;
        startOfFrame         = sof;
        ghostDrawingRequest  = g;
        HitEdgeCode          = code;
        wallDrawingRequest   = w;
        pacmanDrawingRequest = p;
        hw = g && w && m_active && (int'(code) < 5);
        hp = g && p && m_active;
        exp_valid = 1'b0;
        exp_catch = 1'b0;
        if (sof) begin
            if (m_active) begin
                exp_edges = m_mask;
                exp_valid = (m_mask != 0);
                exp_pix   = 8'(m_cnt);
                m_mask    = '0;
                m_cnt     = 0;
                m_caught  = 0;
            end
            m_active = 1;
        end
        if (hw) begin
            m_mask[code] = 1'b1;
            if (m_cnt < 255) m_cnt++;
        end
        if (hp && !m_caught) begin
            exp_catch = 1'b1;
            m_caught  = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        startOfFrame = 1'b0; ghostDrawingRequest = 1'b0; HitEdgeCode = 3'd0;
        wallDrawingRequest = 1'b0; pacmanDrawingRequest = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (wallHitValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", wallHitValid); end
        n_checks++; if (wallHitEdges !== 5'b0) begin n_fail++; $display("FAIL reset_edges got=%b exp=00000", wallHitEdges); end
        n_checks++; if (pacmanCatch !== 1'b0) begin n_fail++; $display("FAIL reset_catch got=%b exp=0", pacmanCatch); end
`ifdef GHOST_HIT_PIXEL_COUNT_EN
        n_checks++; if (wallHitPixels !== 8'd0) begin n_fail++; $display("FAIL reset_pixels got=%0d exp=0", wallHitPixels); end
`endif
        #3 resetN = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_idle_frames();
        for (int f = 0; f < 3; f++) begin
            step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
            for (int c = 0; c < 12; c++) begin
                n_checks++;
                if (wallHitValid !== 1'b0 || wallHitEdges !== 5'b0) begin
                    n_fail++;
                    $display("FAIL idle_frames f=%0d c=%0d got valid=%b edges=%b exp 0/00000",
                             f, c, wallHitValid, wallHitEdges);
                end
                step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
            end
        end
    endtask

    task automatic test_wall_edges();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 3'd1, 1'b1, 1'b0);
        idle(3);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 3'd3, 1'b1, 1'b0);
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        n_checks++; if (wallHitValid !== 1'b1) begin n_fail++; $display("FAIL wall_valid got=%b exp=1", wallHitValid); end
        n_checks++; if (wallHitEdges !== 5'b01010) begin n_fail++; $display("FAIL wall_edges got=%b exp=01010", wallHitEdges); end
`ifdef GHOST_HIT_PIXEL_COUNT_EN
        n_checks++; if (wallHitPixels !== 8'd20) begin n_fail++; $display("FAIL wall_pixels got=%0d exp=20", wallHitPixels); end
`endif
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        n_checks++; if (wallHitValid !== 1'b0) begin n_fail++; $display("FAIL wall_valid_pulse got=%b exp=0", wallHitValid); end
        n_checks++; if (wallHitEdges !== 5'b01010) begin n_fail++; $display("FAIL wall_edges_hold got=%b exp=01010", wallHitEdges); end
    endtask

    task automatic test_pacman_catch();
        int pulses;
        idle(2);
        step(1'b0, 1'b1, 3'd0, 1'b0, 1'b1);
        n_checks++; if (pacmanCatch !== 1'b1) begin n_fail++; $display("FAIL catch_first got=%b exp=1", pacmanCatch); end
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
            if (pacmanCatch === 1'b1) pulses++;
        end
        step(1'b0, 1'b1, 3'd0, 1'b0, 1'b1);
        if (pacmanCatch === 1'b1) pulses++;
        idle(2);
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL catch_once extra_pulses=%0d exp=0", pulses); end
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        idle(3);
        step(1'b0, 1'b1, 3'd0, 1'b0, 1'b1);
        n_checks++; if (pacmanCatch !== 1'b1) begin n_fail++; $display("FAIL catch_next_frame got=%b exp=1", pacmanCatch); end
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        n_checks++; if (pacmanCatch !== 1'b0) begin n_fail++; $display("FAIL catch_pulse_width got=%b exp=0", pacmanCatch); end
    endtask

    task automatic test_invalid_code();
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 3'd6, 1'b1, 1'b0);
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        n_checks++; if (wallHitValid !== 1'b0) begin n_fail++; $display("FAIL invalid_valid got=%b exp=0", wallHitValid); end
        n_checks++; if (wallHitEdges !== 5'b0) begin n_fail++; $display("FAIL invalid_edges got=%b exp=00000", wallHitEdges); end
    endtask

    task automatic test_sof_coincident();
        idle(5);
        step(1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
        n_checks++; if (wallHitValid !== 1'b0 || wallHitEdges !== 5'b0) begin
            n_fail++; $display("FAIL sof_hit_same got valid=%b edges=%b exp 0/00000", wallHitValid, wallHitEdges);
        end
        idle(8);
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        n_checks++; if (wallHitValid !== 1'b1 || wallHitEdges !== 5'b00001) begin
            n_fail++; $display("FAIL sof_hit_next got valid=%b edges=%b exp 1/00001", wallHitValid, wallHitEdges);
        end
`ifdef GHOST_HIT_PIXEL_COUNT_EN
        n_checks++; if (wallHitPixels !== 8'd1) begin n_fail++; $display("FAIL sof_hit_pixels got=%0d exp=1", wallHitPixels); end
`endif
    endtask

    task automatic test_reset_midframe();
        idle(3);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 3'd2, 1'b1, 1'b0);
        step(1'b0, 1'b1, 3'd2, 1'b1, 1'b1);
        #2 resetN = 1'b0;
        #1;
        n_checks++; if (wallHitValid !== 1'b0 || wallHitEdges !== 5'b0 || pacmanCatch !== 1'b0) begin
            n_fail++; $display("FAIL midreset_outputs got valid=%b edges=%b catch=%b exp 0/00000/0",
                               wallHitValid, wallHitEdges, pacmanCatch);
        end
        model_reset();
        #3 resetN = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3'd2, 1'b1, 1'b0);
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        n_checks++; if (wallHitValid !== 1'b0 || wallHitEdges !== 5'b0) begin
            n_fail++; $display("FAIL midreset_no_publish got valid=%b edges=%b exp 0/00000", wallHitValid, wallHitEdges);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3'd4, 1'b1, 1'b0);
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        n_checks++; if (wallHitValid !== 1'b1 || wallHitEdges !== 5'b10000) begin
            n_fail++; $display("FAIL midreset_new_hits got valid=%b edges=%b exp 1/10000", wallHitValid, wallHitEdges);
        end
    endtask

    task automatic test_random();
        int gap;
        int shown;
        bit bad;
        gap = 0;
        shown = 0;
        for (int i = 0; i < 4000; i++) begin
            logic sof;
            sof = (gap >= 3) && ($urandom_range(0, 59) == 0);
            gap = sof ? 0 : gap + 1;
            step(sof, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0));
            bad = (wallHitValid !== exp_valid) || (wallHitEdges !== exp_edges) ||
                  (pacmanCatch !== exp_catch);
`ifdef GHOST_HIT_PIXEL_COUNT_EN
            bad = bad || (wallHitPixels !== exp_pix);
`endif
            n_checks++;
            if (bad) begin
                n_fail++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL random cyc=%0d got v=%b e=%b c=%b exp v=%b e=%b c=%b",
                             i, wallHitValid, wallHitEdges, pacmanCatch, exp_valid, exp_edges, exp_catch);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_frames();
        test_wall_edges();
        test_pacman_catch();
        test_invalid_code();
        test_sof_coincident();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
